// File: rtl/lif_pkg.sv
// Shared types, default sizing and saturating arithmetic for the spike-rate monitor.
package lif_pkg;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} window_state_t;
  typedef enum logic {NO_REF = 1'b0, TIMING = 1'b1} isi_state_t;

  localparam int unsigned DEF_WINDOW_CYCLES = 1000;
  localparam int unsigned DEF_WINDOW_W      = 16;
  localparam int unsigned DEF_CNT_W         = 8;
  localparam int unsigned DEF_ISI_W         = 16;
  localparam int unsigned DEF_BURST_THRESH  = 32;

  function automatic logic [31:0] sat_add(input logic [31:0] val, input logic inc,
                                          input logic [31:0] max_val);
    logic [31:0] r;
    r = val;
    if (inc && (val < max_val)) r = val + 32'd1;
    return r;
  endfunction

endpackage

// File: rtl/spike_isi_timer.sv
// Inter-spike interval timer: NO_REF (waiting for a reference edge) | TIMING (counting since last edge).
module spike_isi_timer
  import lif_pkg::*;
#(
  parameter int unsigned ISI_W = DEF_ISI_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             evt,
  output logic [ISI_W-1:0] isi_out,
  output logic             isi_valid
);

  localparam logic [31:0] ISI_MAX = (32'd1 << ISI_W) - 32'd1;

  isi_state_t       state_q, state_d;
  logic [ISI_W-1:0] cnt_q, cnt_d, isi_q, isi_d, cnt_inc;
  logic             valid_q, valid_d, timing;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= NO_REF;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!en)                                  state_d = NO_REF;
    else if ((state_q == NO_REF) && evt)      state_d = TIMING;
  end

  always_comb begin
    timing = (state_q == TIMING) && en;
  end

  // sat(cnt+1) serves both as the running count and as the reported interval
  always_comb begin
    cnt_inc = ISI_W'(sat_add(32'(cnt_q), 1'b1, ISI_MAX));
    cnt_d   = '0;
    isi_d   = isi_q;
    valid_d = 1'b0;
    if (timing) begin
      if (evt) begin
        isi_d   = cnt_inc;
        valid_d = 1'b1;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      isi_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      isi_q   <= isi_d;
      valid_q <= valid_d;
    end
  end

  assign isi_out   = isi_q;
  assign isi_valid = valid_q;

endmodule

// File: rtl/spike_rate_monitor.sv
// Windowed spike-rate counter with burst flag; ISI measured by spike_isi_timer.
// Window FSM: IDLE (disabled / waiting for en) | RUN (counting edges in a window).
module spike_rate_monitor
  import lif_pkg::*;
#(
  parameter int unsigned WINDOW_CYCLES = DEF_WINDOW_CYCLES,
  parameter int unsigned WINDOW_W      = DEF_WINDOW_W,
  parameter int unsigned CNT_W         = DEF_CNT_W,
  parameter int unsigned ISI_W         = DEF_ISI_W,
  parameter int unsigned BURST_THRESH  = DEF_BURST_THRESH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             spike_in,
  output logic [CNT_W-1:0] rate_out,
  output logic             rate_valid,
  output logic [ISI_W-1:0] isi_out,
  output logic             isi_valid,
  output logic             burst,
  output logic             window_active
);

  localparam logic [31:0]         CNT_MAX  = (32'd1 << CNT_W) - 32'd1;
  localparam logic [WINDOW_W-1:0] WIN_LAST = WINDOW_W'(WINDOW_CYCLES - 1);

  window_state_t       state_q, state_d;
  logic                spike_prev_q, evt, running, closing;
  logic [WINDOW_W-1:0] win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0]    spike_cnt_q, spike_cnt_d, rate_q, rate_d, cnt_inc;
  logic                rate_valid_q, rate_valid_d, burst_q, burst_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) spike_prev_q <= 1'b0;
    else     spike_prev_q <= spike_in;
  end

  assign evt = spike_in & ~spike_prev_q & en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en)  state_d = RUN;
      RUN:     if (!en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    running       = (state_q == RUN) && en;
    closing       = running && (win_cnt_q == WIN_LAST);
    window_active = (state_q == RUN);
  end

  // An edge on the closing cycle still belongs to the window being closed
  always_comb begin
    cnt_inc      = CNT_W'(sat_add(32'(spike_cnt_q), evt, CNT_MAX));
    win_cnt_d    = '0;
    spike_cnt_d  = '0;
    rate_d       = rate_q;
    rate_valid_d = 1'b0;
    burst_d      = burst_q & en;
    if (closing) begin
      rate_d       = cnt_inc;
      rate_valid_d = 1'b1;
      burst_d      = (32'(cnt_inc) >= 32'(BURST_THRESH));
    end else if (running) begin
      win_cnt_d   = win_cnt_q + WINDOW_W'(1);
      spike_cnt_d = cnt_inc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_cnt_q    <= '0;
      spike_cnt_q  <= '0;
      rate_q       <= '0;
      rate_valid_q <= 1'b0;
      burst_q      <= 1'b0;
    end else begin
      win_cnt_q    <= win_cnt_d;
      spike_cnt_q  <= spike_cnt_d;
      rate_q       <= rate_d;
      rate_valid_q <= rate_valid_d;
      burst_q      <= burst_d;
    end
  end

  assign rate_out   = rate_q;
  assign rate_valid = rate_valid_q;
  assign burst      = burst_q;

  spike_isi_timer #(
    .ISI_W(ISI_W)
  ) u_isi (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .evt      (evt),
    .isi_out  (isi_out),
    .isi_valid(isi_valid)
  );

endmodule

// File: tb/tb_spike_rate_monitor.sv
// Directed and random stimulus against a timestamp-based reference model of the monitor.
module tb_spike_rate_monitor;

  localparam int W    = 100;
  localparam int CW   = 5;
  localparam int IW   = 5;
  localparam int TH   = 20;
  localparam int CMAX = (1 << CW) - 1;
  localparam int IMAX = (1 << IW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic          spike_in = 1'b0;
  logic [CW-1:0] rate_out;
  logic          rate_valid;
  logic [IW-1:0] isi_out;
  logic          isi_valid;
  logic          burst;
  logic          window_active;

  spike_rate_monitor #(
    .WINDOW_CYCLES(W),
    .WINDOW_W     (8),
    .CNT_W        (CW),
    .ISI_W        (IW),
    .BURST_THRESH (TH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .spike_in     (spike_in),
    .rate_out     (rate_out),
    .rate_valid   (rate_valid),
    .isi_out      (isi_out),
    .isi_valid    (isi_valid),
    .burst        (burst),
    .window_active(window_active)
  );

  always #5 clk = ~clk;

  int     total = 0;
  int     passed = 0;
  longint cyc = 0;

  // Reference model: window start time, event timestamps in the window, last event time
  bit     m_prev, m_run;
  longint m_start, m_last;
  longint win_ev[$];
  int     e_rate, e_isi;
  bit     e_rv, e_iv, e_burst, e_active;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d at cycle %0d", tag, got, exp, cyc);
  endtask

  task automatic check_all();
    check("rate_out",      32'(rate_out),      32'(e_rate));
    check("rate_valid",    32'(rate_valid),    32'(e_rv));
    check("isi_out",       32'(isi_out),       32'(e_isi));
    check("isi_valid",     32'(isi_valid),     32'(e_iv));
    check("burst",         32'(burst),         32'(e_burst));
    check("window_active", 32'(window_active), 32'(e_active));
  endtask

  task automatic model_reset();
    m_prev = 0; m_run = 0; m_last = -1; m_start = 0;
    win_ev.delete();
    e_rate = 0; e_isi = 0; e_rv = 0; e_iv = 0; e_burst = 0; e_active = 0;
  endtask

  task automatic model_edge(input bit s, input bit e);
    bit ev;
    ev = s && !m_prev && e;
    m_prev = s;
    e_rv = 0;
    e_iv = 0;
    if (!e) begin
      m_run = 0;
      win_ev.delete();
      e_burst = 0;
      m_last = -1;
    end else begin
      if (!m_run) begin
        m_run = 1;
        m_start = cyc + 1;
      end else begin
        if (ev) win_ev.push_back(cyc);
        if (cyc - m_start == W - 1) begin
          e_rate  = (win_ev.size() > CMAX) ? CMAX : win_ev.size();
          e_rv    = 1;
          e_burst = (e_rate >= TH);
          win_ev.delete();
          m_start = cyc + 1;
        end
      end
      if (ev) begin
        if (m_last >= 0) begin
          e_isi = (cyc - m_last > IMAX) ? IMAX : int'(cyc - m_last);
          e_iv  = 1;
        end
        m_last = cyc;
      end
    end
    e_active = m_run;
  endtask

  task automatic step(input bit s, input bit e);
    spike_in = s;
    en       = e;
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge(s, e);
    cyc++;
    #1 check_all();
  endtask

  initial begin
    model_reset();
    #1 rst = 1'b1;
    #2 check_all();
    repeat (3) step(0, 0);
    rst = 1'b0;

    // quiet window: pulse with zero rate, no ISI
    repeat (W + 5) step(0, 1);

    // one spike every 10 cycles: rate 10, ISI 10, no burst
    for (int i = 0; i < 3 * W; i++) step(i % 10 == 0, 1);

    // toggling every cycle: 50 edges saturate the rate, ISI 2, burst
    for (int i = 0; i < 2 * W; i++) step(i % 2 == 0, 1);

    // idle window clears burst; the following gap saturates ISI
    repeat (W + 10) step(0, 1);

    // exactly the burst threshold per window
    for (int i = 0; i < 2 * W; i++) step(i % 5 == 0, 1);

    // edge only on the closing cycle of each window
    for (int i = 0; i < 3 * W; i++) step((cyc - m_start) == W - 1, 1);

    for (int i = 0; i < 4 * W; i++) step($urandom_range(0, 3) == 0, 1);

    // drop en mid-window: partial window discarded, rate_out holds
    for (int i = 0; i < 2 * W && (cyc - m_start) != 50; i++) step($urandom_range(0, 1) == 1, 1);
    repeat (5) step(0, 0);

    // asynchronous reset in the middle of a window
    for (int i = 0; i < 60; i++) step($urandom_range(0, 2) == 0, 1);
    rst = 1'b1;
    #2 begin
      model_reset();
      check_all();
    end
    repeat (2) step(0, 1);
    rst = 1'b0;

    // first spike after re-enable is only a reference
    repeat (3) step(0, 1);
    step(1, 1);
    check("first_isi_valid", 32'(isi_valid), 32'd0);
    repeat (12) step(0, 1);
    step(1, 1);

    for (int i = 0; i < 10 * W; i++) step($urandom_range(0, 2) == 0, $urandom_range(0, 40) != 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
